// File: rtl/bus_demux_decode_if.sv
// CPU-side bus bundle for the demultiplexing address decoder.
// master = CPU/bench, slave = decoder.
interface bus_demux_decode_if;
   logic        ALE;
   logic        IOM;
   logic        RD;
   logic        WR;
   logic [7:0]  AD;
   logic [11:0] A;
   logic [19:0] Address;
   logic        CS_MEM0;
   logic        CS_MEM1;
   logic        CS_IO0;
   logic        CS_IO1;
   logic        READY;
   logic        BUS_ERR;

   modport master (
      output ALE, IOM, RD, WR, AD, A,
      input  Address, CS_MEM0, CS_MEM1, CS_IO0, CS_IO1, READY, BUS_ERR
   );

   modport slave (
      input  ALE, IOM, RD, WR, AD, A,
      output Address, CS_MEM0, CS_MEM1, CS_IO0, CS_IO1, READY, BUS_ERR
   );
endinterface

// File: rtl/bus_demux_decode.sv
// Latches the multiplexed CPU address, decodes chip selects and
// generates READY with per-region wait states plus BUS_ERR pulses.
module bus_demux_decode #(
   parameter int unsigned MEM0_WS = 0,
   parameter int unsigned MEM1_WS = 2,
   parameter int unsigned IO_WS   = 1
) (
   input  logic CLK,
   input  logic RESET,
   bus_demux_decode_if.slave bus
);

   if (MEM0_WS > 15 || MEM1_WS > 15 || IO_WS > 15) begin : g_ws_chk
      $error("bus_demux_decode: wait-state parameter exceeds 15");
   end

   localparam logic [3:0] WS0  = 4'(MEM0_WS);
   localparam logic [3:0] WS1  = 4'(MEM1_WS);
   localparam logic [3:0] WSIO = 4'(IO_WS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DATA = 2'd3;

   logic [1:0]  state;
   logic [19:0] addr_q;
   logic [3:0]  cs_q;
   logic [3:0]  cnt;
   logic        err_q;
   logic        rd_cyc;
   logic [3:0]  dec;
   logic [3:0]  ws_sel;
   logic        rd_lo;
   logic        wr_lo;

   assign rd_lo = !bus.RD;
   assign wr_lo = !bus.WR;

   // cs bit order: {IO1, IO0, MEM1, MEM0}; A[7:0] is address 15:8
   always_comb begin
      dec = '0;
      unique case (1'b1)
         !bus.IOM && !bus.A[11]:          dec = 4'b0001;
         !bus.IOM &&  bus.A[11]:          dec = 4'b0010;
         bus.IOM && bus.A[7:0] == 8'h00:  dec = 4'b0100;
         bus.IOM && bus.A[7:0] == 8'hFF:  dec = 4'b1000;
         default:                         dec = '0;
      endcase
   end

   always_comb begin
      ws_sel = '0;
      unique case (1'b1)
         cs_q[0]:          ws_sel = WS0;
         cs_q[1]:          ws_sel = WS1;
         cs_q[2], cs_q[3]: ws_sel = WSIO;
         default:          ws_sel = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= IDLE;
         addr_q <= '0;
         cs_q   <= '0;
         cnt    <= '0;
         err_q  <= 1'b0;
         rd_cyc <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (bus.ALE) begin
            state  <= ADDR;
            addr_q <= {bus.A, bus.AD};
            cs_q   <= dec;
            err_q  <= (state == WAIT) || (state == DATA);
         end else begin
            case (state)
               ADDR: begin
                  if (rd_lo && wr_lo) begin
                     err_q <= 1'b1;
                     cs_q  <= '0;
                     state <= IDLE;
                  end else if (rd_lo || wr_lo) begin
                     rd_cyc <= rd_lo;
                     if (cs_q == '0) begin
                        // unmapped: complete anyway so the CPU never hangs
                        err_q <= 1'b1;
                        state <= DATA;
                     end else begin
                        cnt   <= ws_sel;
                        state <= (ws_sel == '0) ? DATA : WAIT;
                     end
                  end
               end
               WAIT: begin
                  if (rd_cyc ? bus.RD : bus.WR) begin
                     err_q <= 1'b1;
                     cs_q  <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt - 4'd1;
                     if (cnt == 4'd1) state <= DATA;
                  end
               end
               DATA: begin
                  if (bus.RD && bus.WR) begin
                     cs_q  <= '0;
                     state <= IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.Address = addr_q;
   assign bus.CS_MEM0 = cs_q[0];
   assign bus.CS_MEM1 = cs_q[1];
   assign bus.CS_IO0  = cs_q[2];
   assign bus.CS_IO1  = cs_q[3];
   assign bus.READY   = (state == IDLE) || (state == DATA);
   assign bus.BUS_ERR = err_q;

endmodule
